config_info_apb: RTL
====================

# config_info_apb

APB responder that publishes the build-time hardware configuration (ID, ISA bitmap, reset vector, physical memory map) to software, plus a writable scratch word and a 64-bit uptime counter with atomic high-half snapshot. Sits behind the AHB-to-APB bridge in the uncore alongside GPIO/UART/SPI, so boot code and the test harness can discover the platform without hard-coding addresses. Each transfer uses the standard setup/access phases with a parameterised number of wait states.

## Interface
- HW_ID, 32'h5741_4C59, value of ID register
- ISA_BITS, 32'h0000_1100, misa-style extension bitmap (I, M)
- RESET_VEC, 32'h0000_1000, reported reset vector
- NREGIONS, 8, memory-map entries, 1..8
- REGION_TABLE, {SPI, PLIC, UART, GPIO, CLINT, EXT_MEM, UNCORE_RAM, BOOTROM} base/range pairs, packed [NREGIONS*64-1:0], entry i = {range_i, base_i} at bits [64i+63:64i]; entry 0 = BOOTROM 0x1000/0xFFF, entry 2 = EXT_MEM 0x2000_0000/0x0E00_0000
- WAIT_CYCLES, 1, access-phase wait states, 0..7
- UPTIME_RESET, 64'h0, uptime counter reset value (bench hook)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- PSEL  in  1  select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write
- PADDR  in  8  byte address, [1:0] ignored
- PWDATA  in  32  write data
- PSTRB  in  4  write byte enables
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response

## Operation
- Register map (word offsets): 0x00 ID; 0x04 ISA_BITS; 0x08 {16'h0, WAIT_CYCLES[7:0], NREGIONS[7:0]}; 0x0C RESET_VEC; 0x10 SCRATCH (RW, reset 0); 0x14 UPTIME_LO; 0x18 UPTIME_HI snapshot (reset 0); 0x1C reserved (reads 0, no error); 0x40+8i BASE_i, 0x44+8i RANGE_i for i<NREGIONS.
- Unmapped address (0x20–0x3F, region slots ≥NREGIONS, ≥0x80): read returns 0, PSLVERR=1.
- Writes: only SCRATCH, byte-wise per PSTRB; any other address → PSLVERR=1, no state change. PSTRB=0 to SCRATCH: no change, no error.
- Uptime: 64-bit counter, loads UPTIME_RESET in reset, +1 every cycle otherwise, wraps to 0 after all-ones.
- UPTIME_LO read: full counter sampled in setup cycle; PRDATA = sample[31:0]; on completion UPTIME_HI snapshot ← sample[63:32]. UPTIME_HI read returns snapshot only, never live counter.
- FSM: IDLE → WAIT on PSEL & !PENABLE (setup): latch address, direction, wdata, strb, read data/sample; load wait counter = WAIT_CYCLES. WAIT: while PENABLE & counter≠0, decrement; PENABLE & counter=0 → PREADY=1, commit write/snapshot, → IDLE.
- PSEL low in WAIT (abort): → IDLE, no write, no snapshot, no PREADY.
- PSEL & PENABLE seen in IDLE (no setup): ignored, PREADY stays 0.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, FSM=IDLE, SCRATCH=0, snapshot=0, counter=UPTIME_RESET. Reset mid-transfer discards it.
- Outputs registered-state driven; PRDATA and PSLVERR are 0 whenever PREADY=0.
- Latency: setup cycle + WAIT_CYCLES low-PREADY access cycles + 1 completion cycle; WAIT_CYCLES=0 → PREADY high in first access cycle (2-cycle transfer).
- SCRATCH write visible to a read whose setup follows the completion cycle.
- Read data reflects state at setup cycle; a write completing concurrently cannot occur (single responder, one transfer in flight).
- Back-to-back transfers: next setup may occur the cycle after completion.

## Test plan
- Reset, read 0x00 (WAIT_CYCLES=1) → one access cycle PREADY=0, next PREADY=1, PRDATA=0x5741_4C59, PSLVERR=0; read 0x08 → 0x0000_0108.
- Write SCRATCH 0xDEAD_BEEF PSTRB=4'b0101, then read 0x10 → 0x00AD_00EF; PSTRB=0 write → unchanged, PSLVERR=0.
- Write 0x00 with 0x1234 → PSLVERR=1 at completion; reread ID 0x5741_4C59; read 0x80 → PRDATA=0, PSLVERR=1; read 0x50 → 0x2000_0000, 0x54 → 0x0E00_0000.
- UPTIME_RESET=64'h0000_0000_FFFF_FFFE, setup of UPTIME_LO read 3 cycles after reset release → LO=0x0000_0001; read 0x18 → 0x0000_0001 (carry captured atomically).
- Start SCRATCH write 0x55, drop PSEL during wait cycle → PREADY never asserts, SCRATCH unchanged; following read completes normally.
- Assert reset during WAIT of a SCRATCH write → PREADY=0, SCRATCH=0 after reset; WAIT_CYCLES=0 build: back-to-back reads complete in 2 cycles each.

Source files
------------

// File: rtl/config_info_apb.sv
// APB responder publishing build-time platform configuration, a scratch word and a
// 64-bit uptime counter whose high half is snapshotted atomically by UPTIME_LO reads.
module config_info_apb #(
  parameter logic [31:0]            HW_ID        = 32'h5741_4C59,
  parameter logic [31:0]            ISA_BITS     = 32'h0000_1100,
  parameter logic [31:0]            RESET_VEC    = 32'h0000_1000,
  parameter int unsigned            NREGIONS     = 8,
  parameter logic [NREGIONS*64-1:0] REGION_TABLE = {
    32'h0000_0FFF, 32'h1000_2000,   // SPI
    32'h03FF_FFFF, 32'h0C00_0000,   // PLIC
    32'h0000_0FFF, 32'h1000_1000,   // UART
    32'h0000_0FFF, 32'h1000_0000,   // GPIO
    32'h0000_FFFF, 32'h0200_0000,   // CLINT
    32'h0E00_0000, 32'h2000_0000,   // EXT_MEM
    32'h0000_FFFF, 32'h0001_0000,   // UNCORE_RAM
    32'h0000_0FFF, 32'h0000_1000    // BOOTROM
  },
  parameter int unsigned            WAIT_CYCLES  = 1,
  parameter logic [63:0]            UPTIME_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        wr_q;
  logic        is_scratch_q;
  logic        is_uplo_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic [31:0] sample_hi_q;
  logic        pready_q;
  logic [31:0] prdata_q;
  logic        pslverr_q;
  logic [31:0] scratch_q;
  logic [31:0] snapshot_q;
  logic [63:0] uptime_q;

  logic [5:0]  word;
  logic [31:0] rd_data;
  logic        rd_err;
  logic [31:0] resp_data;
  logic        resp_err;

  assign word = PADDR[7:2];

  // Read decode against current state; captured in the setup cycle.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (word[5] || (word[4:3] == 2'b01)) begin
      rd_err = 1'b1;
    end else if (word[4]) begin
      if (32'(word[3:1]) < NREGIONS) begin
        rd_data = REGION_TABLE[{word[3:0], 5'd0} +: 32];
      end else begin
        rd_err = 1'b1;
      end
    end else begin
      case (word[2:0])
        3'd0:    rd_data = HW_ID;
        3'd1:    rd_data = ISA_BITS;
        3'd2:    rd_data = {16'h0, 8'(WAIT_CYCLES), 8'(NREGIONS)};
        3'd3:    rd_data = RESET_VEC;
        3'd4:    rd_data = scratch_q;
        3'd5:    rd_data = uptime_q[31:0];
        3'd6:    rd_data = snapshot_q;
        default: rd_data = '0;
      endcase
    end
  end

  always_comb begin
    resp_data = PWRITE ? 32'h0 : rd_data;
    resp_err  = PWRITE ? (word != 6'd4) : rd_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      is_scratch_q <= 1'b0;
      is_uplo_q    <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      sample_hi_q  <= '0;
      pready_q     <= 1'b0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      scratch_q    <= '0;
      snapshot_q   <= '0;
      uptime_q     <= UPTIME_RESET;
    end else begin
      uptime_q <= uptime_q + 64'd1;
      case (state_q)
        StIdle: begin
          if (PSEL && !PENABLE) begin
            state_q      <= StWait;
            cnt_q        <= WaitInit;
            wr_q         <= PWRITE;
            is_scratch_q <= (word == 6'd4);
            is_uplo_q    <= (word == 6'd5);
            wdata_q      <= PWDATA;
            strb_q       <= PSTRB;
            resp_data_q  <= resp_data;
            resp_err_q   <= resp_err;
            sample_hi_q  <= uptime_q[63:32];
            if (WaitInit == 3'd0) begin
              pready_q  <= 1'b1;
              prdata_q  <= resp_data;
              pslverr_q <= resp_err;
            end
          end
        end
        StWait: begin
          if (!PSEL) begin
            // Master abandoned the transfer: nothing is committed.
            state_q   <= StIdle;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
          end else if (PENABLE) begin
            if (pready_q) begin
              if (wr_q && is_scratch_q) begin
                for (int b = 0; b < 4; b++) begin
                  if (strb_q[b]) scratch_q[8*b +: 8] <= wdata_q[8*b +: 8];
                end
              end
              if (!wr_q && is_uplo_q) snapshot_q <= sample_hi_q;
              state_q   <= StIdle;
              pready_q  <= 1'b0;
              prdata_q  <= '0;
              pslverr_q <= 1'b0;
            end else if (cnt_q <= 3'd1) begin
              cnt_q     <= '0;
              pready_q  <= 1'b1;
              prdata_q  <= resp_data_q;
              pslverr_q <= resp_err_q;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule
